tlp_tx_arbiter: RTL and testbench
=================================

# tlp_tx_arbiter

Arbitrates the PCIe TX AXI-stream between two TLP sources, on the PCIe user clock domain:
- the XGMII-RX FIFO, carrying 72-bit words of 8 flag bits plus 64 data bits, written by the XGMII receive engine;
- the local host-side TLP requester.

The block strips inter-frame filler words from the FIFO stream and converts the flag byte into tkeep/tlast. It grants the output per whole TLP and never interleaves TLPs. It also closes TLPs that the FIFO stream truncates, so the PCIe core never sees an unterminated packet.

## Interface
- PRIO_FIFO, 0: 0 = round-robin at TLP boundaries; 1 = FIFO has strict priority.
- CNT_W, 16: width of the statistics counters.

- clk  in  1  PCIe user clock; read side of the XGMII-RX FIFO.
- sys_rst  in  1  Synchronous, active-high reset.
- fifo_dout  in  72  FWFT head word; valid while !fifo_empty.
- fifo_empty  in  1  FIFO empty.
- fifo_rd_en  out  1  Pops the head word.
- req_tdata / req_tkeep / req_tlast  in  64/8/1  Local requester stream.
- req_tvalid  in  1; req_tready  out  1.
- s_axis_tx_tdata / s_axis_tx_tkeep / s_axis_tx_tlast  out  64/8/1  To the PCIe core.
- s_axis_tx_tvalid  out  1; s_axis_tx_tready  in  1.
- err_trunc  out  1  One-cycle pulse when a FIFO TLP is force-terminated.
- err_orphan  out  1  One-cycle pulse when a non-start word is discarded in IDLE.
- fifo_pktcount / req_pktcount  out  CNT_W  TLPs completed per source.

## Operation
- FIFO flag byte fifo_dout[67:64]:
  - bit0 = start, bit1 = end;
  - bit2 = lower DW valid (maps to tkeep[3:0]), bit3 = upper DW valid (maps to tkeep[7:4]);
  - flags == 0 marks a filler word, which is always popped and discarded.
- Data bits [63:0] pass through unchanged.
- States: IDLE, GNT_FIFO, GNT_REQ.
- IDLE:
  - filler word: pop and discard;
  - non-start data word: pop, discard, pulse err_orphan;
  - candidates are a FIFO start word and req_tvalid.
  - If both are candidates: PRIO_FIFO=1 grants FIFO; otherwise grant the source that did not win last. last_grant resets to REQ, so FIFO wins first.
- GNT_REQ:
  - req_tready = output slot free; beats are copied into the output register;
  - return to IDLE when the req_tlast beat is accepted into the slot; req_pktcount++.
- GNT_FIFO uses a one-word hold register H. On each FIFO word n:
  - data word, no end: emit H with tlast=0; n goes into H.
  - data word with end: emit H with tlast=0, then n with tlast=1; go to IDLE; fifo_pktcount++.
  - start word with end (1-word TLP): emit directly with tlast=1.
  - filler word or start word: emit H with tlast=1; pulse err_trunc; fifo_pktcount++; go to IDLE.
    - A filler word is popped; a start word is left in the FIFO.
- fifo_rd_en = !fifo_empty AND the FIFO path can place its next output (slot free or freeing this cycle) AND the state allows reading.
- Output register:
  - holds tdata/tkeep/tlast/tvalid until s_axis_tx_tready;
  - the slot is free when !tvalid || tready.
- Counters wrap modulo 2^CNT_W.

## Timing
- Reset values:
  - s_axis_tx_tvalid=0, tlast=0, tdata=0, tkeep=0;
  - fifo_rd_en=0, req_tready=0, err_*=0, counters=0;
  - state=IDLE, H empty, last_grant=REQ.
- Reset mid-packet drops the packet in flight with no tlast emitted.
- Requester path: beat accepted at cycle t is on s_axis_tx_* at t+1.
- FIFO path, non-end word read at t: emitted at t+1 after its successor's read.
- FIFO path, end word read at t: emitted at t+1 if H was already emitted, else at t+2.
- Back-to-back TLPs from one source: at most 1 idle cycle at a grant change.
- Zero bubbles within a TLP when the source streams and tready=1.
- tready low: the output holds stable; fifo_rd_en and req_tready fall in the same cycle (combinational).

## Configuration
- TLP_ARB_STATS_EN:
  - defined: fifo_pktcount, req_pktcount, err_trunc and err_orphan are live.
  - undefined: all four are tied to 0, and the arbitration logic is unchanged.

## Structure
- Shared package holds the flag bit indices (START, END, LO_VALID, HI_VALID), the filler encoding, and the state constants.
- The flag-format constants are shared with the XGMII receive engine.
- One sub-module: tlp_axis_slot, the single-entry output register with its free/accept logic.

## Test plan
- FIFO TLP of 3DW: words flags 1101, 0110 -> 2 beats, tkeep 0xFF then 0x0F, tlast on beat 2; fifo_pktcount=1.
- Filler words (flags 0) between TLPs -> popped, never on the output.
- Both sources request simultaneously for 4 rounds, PRIO_FIFO=0 -> grants alternate FIFO, REQ, FIFO, REQ with whole TLPs and no interleave.
- FIFO words 1101, 1100, then filler -> second word emitted with tlast=1; err_trunc pulses once.
- Word 1100 at head in IDLE -> discarded; err_orphan pulses.
- tready toggled 50% during a 16-beat requester TLP -> data intact and held stable while stalled; sys_rst mid-packet -> tvalid=0 on the next cycle.

Source files
------------

// File: rtl/tlp_tx_arbiter_pkg.sv
// Flag-word format of the XGMII-RX FIFO (shared with the XGMII receive engine)
// and arbiter state encodings.
package tlp_tx_arbiter_pkg;

  localparam int FLAG_START    = 0;
  localparam int FLAG_END      = 1;
  localparam int FLAG_LO_VALID = 2;
  localparam int FLAG_HI_VALID = 3;

  localparam logic [3:0] FLAG_FILLER = 4'b0000;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_GNT_FIFO = 2'd1,
    ST_GNT_REQ  = 2'd2
  } arb_state_e;

  typedef enum logic {
    SRC_FIFO = 1'b0,
    SRC_REQ  = 1'b1
  } arb_src_e;

  function automatic logic [7:0] flags_to_keep(input logic [3:0] flags);
    return {{4{flags[FLAG_HI_VALID]}}, {4{flags[FLAG_LO_VALID]}}};
  endfunction

endpackage

// File: rtl/tlp_tx_arbiter_slot.sv
// Single-entry AXI-stream output register; free when empty or draining this cycle.
module tlp_axis_slot (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic [63:0] data_i,
  input  logic [7:0]  keep_i,
  input  logic        last_i,
  input  logic        tready_i,
  output logic        free_o,
  output logic        tvalid_o,
  output logic [63:0] tdata_o,
  output logic [7:0]  tkeep_o,
  output logic        tlast_o
);

  logic        tvalid_q;
  logic [63:0] tdata_q;
  logic [7:0]  tkeep_q;
  logic        tlast_q;

  assign free_o = !tvalid_q || tready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tkeep_q  <= '0;
      tlast_q  <= 1'b0;
    end else if (load_i) begin
      tvalid_q <= 1'b1;
      tdata_q  <= data_i;
      tkeep_q  <= keep_i;
      tlast_q  <= last_i;
    end else if (tready_i) begin
      tvalid_q <= 1'b0;
    end
  end

  assign tvalid_o = tvalid_q;
  assign tdata_o  = tdata_q;
  assign tkeep_o  = tkeep_q;
  assign tlast_o  = tlast_q;

endmodule

// File: rtl/tlp_tx_arbiter.sv
// Per-TLP arbiter between the XGMII-RX FIFO and the local requester onto the PCIe TX stream.
// Statistics outputs are live only when TLP_ARB_STATS_EN is defined.
//
// state       | meaning
// ST_IDLE     | no TLP owns the output; drop filler/orphan words, pick a source
// ST_GNT_FIFO | FIFO TLP in flight; H holds the word not yet emitted
// ST_GNT_REQ  | requester TLP in flight; beats copied straight to the slot
module tlp_tx_arbiter
  import tlp_tx_arbiter_pkg::*;
#(
  parameter int PRIO_FIFO = 0,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             sys_rst,
  input  logic [71:0]      fifo_dout,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  input  logic [63:0]      req_tdata,
  input  logic [7:0]       req_tkeep,
  input  logic             req_tlast,
  input  logic             req_tvalid,
  output logic             req_tready,
  output logic [63:0]      s_axis_tx_tdata,
  output logic [7:0]       s_axis_tx_tkeep,
  output logic             s_axis_tx_tlast,
  output logic             s_axis_tx_tvalid,
  input  logic             s_axis_tx_tready,
  output logic             err_trunc,
  output logic             err_orphan,
  output logic [CNT_W-1:0] fifo_pktcount,
  output logic [CNT_W-1:0] req_pktcount
);

  arb_state_e  state_q, state_d;
  arb_src_e    last_grant_q, last_grant_d;
  logic [63:0] h_data_q;
  logic [7:0]  h_keep_q;
  logic        h_last_q;

  logic        slot_free;
  logic        ld, ld_last, h_load;
  logic [63:0] ld_data;
  logic [7:0]  ld_keep;
  logic        fifo_inc, req_inc, trunc_ev, orphan_ev;

  logic [3:0]  w_flags;
  logic        w_fill, w_start, w_end, fifo_cand, pick_fifo;
  logic [7:0]  w_keep;

  assign w_flags   = fifo_dout[67:64];
  assign w_fill    = (w_flags == FLAG_FILLER);
  assign w_start   = w_flags[FLAG_START];
  assign w_end     = w_flags[FLAG_END];
  assign w_keep    = flags_to_keep(w_flags);
  assign fifo_cand = !fifo_empty && w_start;
  assign pick_fifo = fifo_cand &&
                     (PRIO_FIFO != 0 || !req_tvalid || last_grant_q == SRC_REQ);

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    fifo_rd_en   = 1'b0;
    req_tready   = 1'b0;
    ld           = 1'b0;
    ld_data      = h_data_q;
    ld_keep      = h_keep_q;
    ld_last      = 1'b0;
    h_load       = 1'b0;
    fifo_inc     = 1'b0;
    req_inc      = 1'b0;
    trunc_ev     = 1'b0;
    orphan_ev    = 1'b0;
    if (!sys_rst && slot_free) begin
      unique case (state_q)
        ST_IDLE: begin
          if (!fifo_empty && !w_start) begin
            fifo_rd_en = 1'b1;
            orphan_ev  = !w_fill;
          end
          if (pick_fifo) begin
            fifo_rd_en   = 1'b1;
            last_grant_d = SRC_FIFO;
            if (w_end) begin
              ld       = 1'b1;
              ld_data  = fifo_dout[63:0];
              ld_keep  = w_keep;
              ld_last  = 1'b1;
              fifo_inc = 1'b1;
            end else begin
              h_load  = 1'b1;
              state_d = ST_GNT_FIFO;
            end
          end else if (req_tvalid) begin
            req_tready   = 1'b1;
            ld           = 1'b1;
            ld_data      = req_tdata;
            ld_keep      = req_tkeep;
            ld_last      = req_tlast;
            last_grant_d = SRC_REQ;
            if (req_tlast) req_inc = 1'b1;
            else           state_d = ST_GNT_REQ;
          end
        end
        ST_GNT_REQ: begin
          req_tready = 1'b1;
          if (req_tvalid) begin
            ld      = 1'b1;
            ld_data = req_tdata;
            ld_keep = req_tkeep;
            ld_last = req_tlast;
            if (req_tlast) begin
              req_inc = 1'b1;
              state_d = ST_IDLE;
            end
          end
        end
        ST_GNT_FIFO: begin
          // H holds the end word: flush it before touching the FIFO again
          if (h_last_q) begin
            ld       = 1'b1;
            ld_last  = 1'b1;
            fifo_inc = 1'b1;
            state_d  = ST_IDLE;
          end else if (!fifo_empty) begin
            if (w_fill || w_start) begin
              fifo_rd_en = w_fill;
              ld         = 1'b1;
              ld_last    = 1'b1;
              trunc_ev   = 1'b1;
              fifo_inc   = 1'b1;
              state_d    = ST_IDLE;
            end else begin
              fifo_rd_en = 1'b1;
              ld         = 1'b1;
              h_load     = 1'b1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= SRC_REQ;
      h_data_q     <= '0;
      h_keep_q     <= '0;
      h_last_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      if (h_load) begin
        h_data_q <= fifo_dout[63:0];
        h_keep_q <= w_keep;
        h_last_q <= w_end;
      end else if (ld && ld_last) begin
        h_last_q <= 1'b0;
      end
    end
  end

  tlp_axis_slot u_slot (
    .clk_i    (clk),
    .rst_i    (sys_rst),
    .load_i   (ld),
    .data_i   (ld_data),
    .keep_i   (ld_keep),
    .last_i   (ld_last),
    .tready_i (s_axis_tx_tready),
    .free_o   (slot_free),
    .tvalid_o (s_axis_tx_tvalid),
    .tdata_o  (s_axis_tx_tdata),
    .tkeep_o  (s_axis_tx_tkeep),
    .tlast_o  (s_axis_tx_tlast)
  );

`ifdef TLP_ARB_STATS_EN
  logic [CNT_W-1:0] fifo_cnt_q, req_cnt_q;
  logic             trunc_q, orphan_q;
  logic             unused_flag_hi;

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      fifo_cnt_q <= '0;
      req_cnt_q  <= '0;
      trunc_q    <= 1'b0;
      orphan_q   <= 1'b0;
    end else begin
      if (fifo_inc) fifo_cnt_q <= fifo_cnt_q + CNT_W'(1);
      if (req_inc)  req_cnt_q  <= req_cnt_q + CNT_W'(1);
      trunc_q  <= trunc_ev;
      orphan_q <= orphan_ev;
    end
  end

  assign fifo_pktcount  = fifo_cnt_q;
  assign req_pktcount   = req_cnt_q;
  assign err_trunc      = trunc_q;
  assign err_orphan     = orphan_q;
  assign unused_flag_hi = ^fifo_dout[71:68];
`else
  logic unused_stats;

  assign fifo_pktcount = '0;
  assign req_pktcount  = '0;
  assign err_trunc     = 1'b0;
  assign err_orphan    = 1'b0;
  assign unused_stats  = ^{fifo_inc, req_inc, trunc_ev, orphan_ev, fifo_dout[71:68]};
`endif

endmodule

// File: tb/tb_tlp_tx_arbiter.sv
// Directed bench for tlp_tx_arbiter: FIFO model, requester driver and output monitor.
module tb_tlp_tx_arbiter;

`ifdef TLP_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [71:0] fifo_dout = '0;
  logic        fifo_empty = 1'b1;
  logic        fifo_rd_en;
  logic [63:0] req_tdata = '0;
  logic [7:0]  req_tkeep = '0;
  logic        req_tlast = 1'b0;
  logic        req_tvalid = 1'b0;
  logic        req_tready;
  logic [63:0] s_axis_tx_tdata;
  logic [7:0]  s_axis_tx_tkeep;
  logic        s_axis_tx_tlast;
  logic        s_axis_tx_tvalid;
  logic        s_axis_tx_tready = 1'b1;
  logic        err_trunc, err_orphan;
  logic [15:0] fifo_pktcount, req_pktcount;

  int vectors = 0;
  int miscompares = 0;
  logic [71:0] fq[$];
  logic [72:0] outq[$];
  logic        rd_s;
  int          trunc_seen = 0, orphan_seen = 0, stab_err = 0;
  logic        stall_q = 1'b0;
  logic [72:0] stall_val = '0;
  logic        stop_tog = 1'b0;
  int          exp_fifo_pkts = 0, exp_req_pkts = 0;

  always #5 clk = ~clk;

  tlp_tx_arbiter #(.PRIO_FIFO(0), .CNT_W(16)) dut (
    .clk              (clk),
    .sys_rst          (sys_rst),
    .fifo_dout        (fifo_dout),
    .fifo_empty       (fifo_empty),
    .fifo_rd_en       (fifo_rd_en),
    .req_tdata        (req_tdata),
    .req_tkeep        (req_tkeep),
    .req_tlast        (req_tlast),
    .req_tvalid       (req_tvalid),
    .req_tready       (req_tready),
    .s_axis_tx_tdata  (s_axis_tx_tdata),
    .s_axis_tx_tkeep  (s_axis_tx_tkeep),
    .s_axis_tx_tlast  (s_axis_tx_tlast),
    .s_axis_tx_tvalid (s_axis_tx_tvalid),
    .s_axis_tx_tready (s_axis_tx_tready),
    .err_trunc        (err_trunc),
    .err_orphan       (err_orphan),
    .fifo_pktcount    (fifo_pktcount),
    .req_pktcount     (req_pktcount)
  );

  task automatic refresh();
    fifo_empty = (fq.size() == 0);
    fifo_dout  = (fq.size() > 0) ? fq[0] : '0;
  endtask

  task automatic push(input logic [3:0] fl, input logic [63:0] d);
    fq.push_back({4'h0, fl, d});
    refresh();
  endtask

  // FWFT FIFO model: pop what the DUT read at this edge
  always @(posedge clk) begin
    rd_s = fifo_rd_en;
    #1;
    if (rd_s && fq.size() > 0) void'(fq.pop_front());
    refresh();
  end

  always @(posedge clk) begin
    if (sys_rst) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q && {s_axis_tx_tlast, s_axis_tx_tkeep, s_axis_tx_tdata} !== stall_val)
        stab_err++;
      if (s_axis_tx_tvalid && s_axis_tx_tready)
        outq.push_back({s_axis_tx_tlast, s_axis_tx_tkeep, s_axis_tx_tdata});
      stall_q   = s_axis_tx_tvalid && !s_axis_tx_tready;
      stall_val = {s_axis_tx_tlast, s_axis_tx_tkeep, s_axis_tx_tdata};
      if (err_trunc)  trunc_seen++;
      if (err_orphan) orphan_seen++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    sys_rst    = 1'b1;
    req_tvalid = 1'b0;
    req_tlast  = 1'b0;
    repeat (2) tick();
    sys_rst = 1'b0;
    exp_fifo_pkts = 0;
    exp_req_pkts  = 0;
  endtask

  task automatic req_send(input int nb, input logic [63:0] base);
    int i = 0;
    int guard = 0;
    while (i < nb && guard < 2000) begin
      req_tvalid = 1'b1;
      req_tdata  = base + 64'(i);
      req_tkeep  = 8'hFF;
      req_tlast  = (i == nb - 1);
      @(posedge clk);
      if (req_tready) i++;
      #1;
      guard++;
    end
    req_tvalid = 1'b0;
    req_tlast  = 1'b0;
    if (i < nb) begin
      vectors++; miscompares++;
      $display("FAIL req_send_timeout: got %0d beats accepted want %0d", i, nb);
    end
  endtask

  task automatic wait_out(input int n, input string name);
    int cyc = 0;
    while (outq.size() < n && cyc < 300) begin
      tick();
      cyc++;
    end
    if (outq.size() < n) begin
      vectors++; miscompares++;
      $display("FAIL %s_timeout: got %0d beats want %0d", name, outq.size(), n);
    end
    repeat (4) tick();
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if (s_axis_tx_tvalid !== 1'b0 || s_axis_tx_tlast !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_valid_last: got %b%b want 00", s_axis_tx_tvalid, s_axis_tx_tlast);
    end
    vectors++;
    if (s_axis_tx_tdata !== 64'h0 || s_axis_tx_tkeep !== 8'h0) begin
      miscompares++;
      $display("FAIL reset_data_keep: got %h/%h want 0/0", s_axis_tx_tdata, s_axis_tx_tkeep);
    end
    vectors++;
    if (fifo_rd_en !== 1'b0 || req_tready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_handshake: got rd_en=%b req_tready=%b want 0 0", fifo_rd_en, req_tready);
    end
    vectors++;
    if ({err_trunc, err_orphan} !== 2'b00 || fifo_pktcount !== 16'd0 || req_pktcount !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_stats: got err=%b%b cnt=%0d/%0d want 00 0/0",
               err_trunc, err_orphan, fifo_pktcount, req_pktcount);
    end
  endtask

  task automatic test_fifo_3dw();
    outq.delete();
    push(4'b1101, 64'h1111_2222_3333_4444);
    push(4'b0110, 64'h5555_6666_7777_8888);
    wait_out(2, "fifo3dw");
    exp_fifo_pkts = 1;
    vectors++;
    if (outq.size() != 2) begin
      miscompares++;
      $display("FAIL fifo3dw_count: got %0d beats want 2", outq.size());
    end
    vectors++;
    if (outq.size() < 1 || outq[0] !== {1'b0, 8'hFF, 64'h1111_2222_3333_4444}) begin
      miscompares++;
      $display("FAIL fifo3dw_beat0: got %h want %h", outq.size() > 0 ? outq[0] : 73'h0,
               {1'b0, 8'hFF, 64'h1111_2222_3333_4444});
    end
    vectors++;
    if (outq.size() < 2 || outq[1] !== {1'b1, 8'h0F, 64'h5555_6666_7777_8888}) begin
      miscompares++;
      $display("FAIL fifo3dw_beat1: got %h want %h", outq.size() > 1 ? outq[1] : 73'h0,
               {1'b1, 8'h0F, 64'h5555_6666_7777_8888});
    end
    vectors++;
    if (fifo_pktcount !== (STATS ? 16'(exp_fifo_pkts) : 16'd0)) begin
      miscompares++;
      $display("FAIL fifo3dw_pktcount: got %0d want %0d", fifo_pktcount,
               STATS ? exp_fifo_pkts : 0);
    end
  endtask

  task automatic test_filler();
    outq.delete();
    orphan_seen = 0;
    push(4'b0000, 64'hDEAD_0000_0000_0001);
    push(4'b0000, 64'hDEAD_0000_0000_0002);
    push(4'b1111, 64'hC0C0_C0C0_0000_0003);
    push(4'b0000, 64'hDEAD_0000_0000_0004);
    push(4'b0000, 64'hDEAD_0000_0000_0005);
    wait_out(1, "filler");
    repeat (4) tick();
    exp_fifo_pkts = 2;
    vectors++;
    if (outq.size() != 1 || outq[0] !== {1'b1, 8'hFF, 64'hC0C0_C0C0_0000_0003}) begin
      miscompares++;
      $display("FAIL filler_output: got %0d beats first %h want 1 beat %h", outq.size(),
               outq.size() > 0 ? outq[0] : 73'h0, {1'b1, 8'hFF, 64'hC0C0_C0C0_0000_0003});
    end
    vectors++;
    if (fq.size() != 0 || orphan_seen != 0) begin
      miscompares++;
      $display("FAIL filler_drained: got fifo_left=%0d orphans=%0d want 0 0", fq.size(), orphan_seen);
    end
    vectors++;
    if (fifo_pktcount !== (STATS ? 16'(exp_fifo_pkts) : 16'd0)) begin
      miscompares++;
      $display("FAIL filler_pktcount: got %0d want %0d", fifo_pktcount, STATS ? exp_fifo_pkts : 0);
    end
  endtask

  task automatic test_round_robin();
    logic [72:0] exp_b [8];
    do_reset();
    outq.delete();
    exp_b[0] = {1'b0, 8'hFF, 64'hF100};
    exp_b[1] = {1'b1, 8'hFF, 64'hF101};
    exp_b[2] = {1'b0, 8'hFF, 64'hA100};
    exp_b[3] = {1'b1, 8'hFF, 64'hA101};
    exp_b[4] = {1'b0, 8'hFF, 64'hF200};
    exp_b[5] = {1'b1, 8'hFF, 64'hF201};
    exp_b[6] = {1'b0, 8'hFF, 64'hA200};
    exp_b[7] = {1'b1, 8'hFF, 64'hA201};
    push(4'b1101, 64'hF100);
    push(4'b1110, 64'hF101);
    push(4'b1101, 64'hF200);
    push(4'b1110, 64'hF201);
    req_send(2, 64'hA100);
    req_send(2, 64'hA200);
    wait_out(8, "rr");
    exp_fifo_pkts = 2;
    exp_req_pkts  = 2;
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (i >= outq.size() || outq[i] !== exp_b[i]) begin
        miscompares++;
        $display("FAIL rr_beat%0d: got %h want %h", i, i < outq.size() ? outq[i] : 73'h0, exp_b[i]);
      end
    end
    vectors++;
    if (outq.size() != 8) begin
      miscompares++;
      $display("FAIL rr_count: got %0d beats want 8", outq.size());
    end
    vectors++;
    if (fifo_pktcount !== (STATS ? 16'd2 : 16'd0) || req_pktcount !== (STATS ? 16'd2 : 16'd0)) begin
      miscompares++;
      $display("FAIL rr_pktcount: got %0d/%0d want %0d/%0d", fifo_pktcount, req_pktcount,
               STATS ? 2 : 0, STATS ? 2 : 0);
    end
  endtask

  task automatic test_trunc();
    outq.delete();
    trunc_seen = 0;
    push(4'b1101, 64'hE1E1_0000_0000_0001);
    push(4'b1100, 64'hE2E2_0000_0000_0002);
    push(4'b0000, 64'h0);
    wait_out(2, "trunc");
    exp_fifo_pkts = 3;
    vectors++;
    if (outq.size() != 2) begin
      miscompares++;
      $display("FAIL trunc_count: got %0d beats want 2", outq.size());
    end
    vectors++;
    if (outq.size() < 2 || outq[0] !== {1'b0, 8'hFF, 64'hE1E1_0000_0000_0001}
        || outq[1] !== {1'b1, 8'hFF, 64'hE2E2_0000_0000_0002}) begin
      miscompares++;
      $display("FAIL trunc_beats: got %h %h want %h %h",
               outq.size() > 0 ? outq[0] : 73'h0, outq.size() > 1 ? outq[1] : 73'h0,
               {1'b0, 8'hFF, 64'hE1E1_0000_0000_0001}, {1'b1, 8'hFF, 64'hE2E2_0000_0000_0002});
    end
    vectors++;
    if (trunc_seen != (STATS ? 1 : 0) || fq.size() != 0) begin
      miscompares++;
      $display("FAIL trunc_pulse: got pulses=%0d fifo_left=%0d want %0d 0",
               trunc_seen, fq.size(), STATS ? 1 : 0);
    end
    vectors++;
    if (fifo_pktcount !== (STATS ? 16'(exp_fifo_pkts) : 16'd0)) begin
      miscompares++;
      $display("FAIL trunc_pktcount: got %0d want %0d", fifo_pktcount, STATS ? exp_fifo_pkts : 0);
    end
  endtask

  task automatic test_orphan();
    outq.delete();
    orphan_seen = 0;
    push(4'b1100, 64'h0BAD_0BAD_0BAD_0BAD);
    repeat (6) tick();
    vectors++;
    if (fq.size() != 0 || outq.size() != 0) begin
      miscompares++;
      $display("FAIL orphan_discard: got fifo_left=%0d beats=%0d want 0 0", fq.size(), outq.size());
    end
    vectors++;
    if (orphan_seen != (STATS ? 1 : 0)) begin
      miscompares++;
      $display("FAIL orphan_pulse: got %0d want %0d", orphan_seen, STATS ? 1 : 0);
    end
  endtask

  task automatic test_stall();
    outq.delete();
    stab_err = 0;
    stop_tog = 1'b0;
    fork
      begin
        while (!stop_tog) begin
          s_axis_tx_tready = ~s_axis_tx_tready;
          tick();
        end
        s_axis_tx_tready = 1'b1;
      end
    join_none
    req_send(16, 64'hB000);
    wait_out(16, "stall");
    stop_tog = 1'b1;
    repeat (2) tick();
    exp_req_pkts = 3;
    for (int i = 0; i < 16; i++) begin
      vectors++;
      if (i >= outq.size() || outq[i] !== {(i == 15), 8'hFF, 64'hB000 + 64'(i)}) begin
        miscompares++;
        $display("FAIL stall_beat%0d: got %h want %h", i, i < outq.size() ? outq[i] : 73'h0,
                 {(i == 15), 8'hFF, 64'hB000 + 64'(i)});
      end
    end
    vectors++;
    if (stab_err != 0) begin
      miscompares++;
      $display("FAIL stall_stable: got %0d changes while stalled want 0", stab_err);
    end
    vectors++;
    if (req_pktcount !== (STATS ? 16'(exp_req_pkts) : 16'd0)) begin
      miscompares++;
      $display("FAIL stall_pktcount: got %0d want %0d", req_pktcount, STATS ? exp_req_pkts : 0);
    end
  endtask

  task automatic test_reset_mid();
    s_axis_tx_tready = 1'b0;
    req_tvalid = 1'b1;
    req_tdata  = 64'h7777_0000_0000_0001;
    req_tkeep  = 8'hFF;
    req_tlast  = 1'b0;
    tick();
    req_tvalid = 1'b0;
    tick();
    vectors++;
    if (s_axis_tx_tvalid !== 1'b1 || s_axis_tx_tdata !== 64'h7777_0000_0000_0001) begin
      miscompares++;
      $display("FAIL midrst_held: got v=%b d=%h want 1 %h", s_axis_tx_tvalid, s_axis_tx_tdata,
               64'h7777_0000_0000_0001);
    end
    sys_rst = 1'b1;
    tick();
    vectors++;
    if (s_axis_tx_tvalid !== 1'b0 || s_axis_tx_tlast !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_drop: got v=%b l=%b want 0 0", s_axis_tx_tvalid, s_axis_tx_tlast);
    end
    sys_rst = 1'b0;
    s_axis_tx_tready = 1'b1;
    vectors++;
    if (req_pktcount !== 16'd0 || fifo_pktcount !== 16'd0) begin
      miscompares++;
      $display("FAIL midrst_counts: got %0d/%0d want 0/0", fifo_pktcount, req_pktcount);
    end
    outq.delete();
    req_send(1, 64'h9999);
    wait_out(1, "midrst_after");
    vectors++;
    if (outq.size() != 1 || outq[0] !== {1'b1, 8'hFF, 64'h9999}) begin
      miscompares++;
      $display("FAIL midrst_after: got %0d beats first %h want 1 beat %h", outq.size(),
               outq.size() > 0 ? outq[0] : 73'h0, {1'b1, 8'hFF, 64'h9999});
    end
  endtask

  initial begin
    test_reset();
    test_fifo_3dw();
    test_filler();
    test_round_robin();
    test_trunc();
    test_orphan();
    test_stall();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
